// File: rtl/fifo8_reader.sv
// Read-side master for the 8-entry DMAC FIFO: drains a programmed burst over the
// rd_en/rd_ack/rd_err handshake and forwards each word on a valid/ready port.
module fifo8_reader #(
    parameter int RETRY_MAX = 3,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        burst_len,
    output logic              rd_en,
    input  logic              rd_ack,
    input  logic              rd_err,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              underflow,
    output logic              timeout,
    output logic [3:0]        xfer_count
);

    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [3:0]    len;
    logic [3:0]    len_clamped;
    logic [RW-1:0] retry_cnt;

    // The FIFO only holds 8 entries, so longer requests are trimmed.
    assign len_clamped = (burst_len > 4'd8) ? 4'd8 : burst_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= 4'd0;
            retry_cnt  <= '0;
            m_data     <= '0;
            xfer_count <= 4'd0;
            underflow  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len <= len_clamped;
                        if (len_clamped == 4'd0) begin
                            state <= S_DONE;
                        end else begin
                            state      <= S_REQ;
                            xfer_count <= 4'd0;
                            retry_cnt  <= '0;
                            underflow  <= 1'b0;
                            timeout    <= 1'b0;
                        end
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    // A silent cycle means the request was lost, typically to a writer collision.
                    if (rd_err) begin
                        underflow <= 1'b1;
                        state     <= S_DONE;
                    end else if (rd_ack) begin
                        m_data    <= fifo_dout;
                        retry_cnt <= '0;
                        state     <= S_HOLD;
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= S_REQ;
                    end else begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        xfer_count <= xfer_count + 4'd1;
                        state      <= ((xfer_count + 4'd1) == len) ? S_DONE : S_REQ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Single-cycle REQ keeps rd_en from ever being high on two consecutive cycles.
    assign rd_en   = (state == S_REQ);
    assign m_valid = (state == S_HOLD);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_fifo8_reader.sv
// Bench for fifo8_reader: a per-burst transaction script predicts every output
// cycle by cycle while acting as the FIFO and consumer.
module tb_fifo8_reader;

    localparam int RETRY_MAX = 3;

    logic        clk = 1'b0;
    logic        reset, start, rd_ack, rd_err, m_ready;
    logic [3:0]  burst_len;
    logic [31:0] fifo_dout;
    logic        rd_en, m_valid, busy, done, underflow, timeout;
    logic [31:0] m_data;
    logic [3:0]  xfer_count;

    fifo8_reader #(.RETRY_MAX(RETRY_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .rd_en(rd_en), .rd_ack(rd_ack), .rd_err(rd_err), .fifo_dout(fifo_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .done(done), .underflow(underflow), .timeout(timeout), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    logic        e_rd_en, e_m_valid, e_busy, e_done, e_underflow, e_timeout;
    logic [31:0] e_m_data;
    logic [3:0]  e_xfer;
    bit          pend_x, pend_u, pend_t;
    bit          chk_en = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, t0 = 0, done_at = -1;
    int          rd_at[$];
    int          mv_at[$];
    logic [31:0] mv_d[$];
    logic [31:0] fq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] qgetd(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_en", {31'd0, rd_en}, {31'd0, e_rd_en});
            chk("m_valid", {31'd0, m_valid}, {31'd0, e_m_valid});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("underflow", {31'd0, underflow}, {31'd0, e_underflow});
            chk("timeout", {31'd0, timeout}, {31'd0, e_timeout});
            chk("m_data", m_data, e_m_data);
            chk("xfer_count", {28'd0, xfer_count}, {28'd0, e_xfer});
            if (rd_en) rd_at.push_back(cyc - t0);
            if (m_valid) begin
                mv_at.push_back(cyc - t0);
                mv_d.push_back(m_data);
            end
            if (done) done_at = cyc - t0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_x) begin e_xfer = e_xfer + 4'd1; pend_x = 1'b0; end
        if (pend_u) begin e_underflow = 1'b1; pend_u = 1'b0; end
        if (pend_t) begin e_timeout = 1'b1; pend_t = 1'b0; end
        start     = 1'b0;
        rd_ack    = 1'b0;
        rd_err    = 1'b0;
        fifo_dout = $urandom;
        m_ready   = 1'($urandom);
    endtask

    task automatic spur();
        start     = 1'($urandom);
        burst_len = 4'($urandom);
    endtask

    task automatic set_ctl(input bit rq, input bit mv, input bit by, input bit dn);
        e_rd_en = rq; e_m_valid = mv; e_busy = by; e_done = dn;
    endtask

    // One burst: len_in requested words, the first coll_n requests go unanswered,
    // m_ready is low for relative cycles rlo_s..rlo_e (directed) or random (rnd).
    task automatic run_burst(input int len_in, input int coll_n, input int rlo_s,
                             input int rlo_e, input bit rnd);
        int L, attempts, nreq, resp, hc, rel;
        bit ended, got, rdy;
        logic [31:0] d;
        step();
        start = 1'b1;
        burst_len = 4'(len_in);
        t0 = cyc;
        rd_at.delete(); mv_at.delete(); mv_d.delete(); done_at = -1;
        set_ctl(0, 0, 0, 0);
        L = (len_in > 8) ? 8 : len_in;
        nreq = 0; ended = 1'b0; d = '0;
        for (int w = 0; w < L && !ended; w++) begin
            attempts = 0; got = 1'b0;
            while (!got && !ended) begin
                step(); spur(); set_ctl(1, 0, 1, 0);
                if (w == 0 && attempts == 0) begin
                    e_xfer = 4'd0; e_underflow = 1'b0; e_timeout = 1'b0;
                end
                if (nreq < coll_n || (rnd && $urandom_range(0, 99) < 20)) resp = 2;
                else if (fq.size() == 0) resp = 1;
                else resp = 0;
                nreq++;
                step(); spur(); set_ctl(0, 0, 1, 0);
                if (resp == 0) begin
                    d = fq.pop_front();
                    rd_ack = 1'b1; fifo_dout = d; got = 1'b1;
                end else if (resp == 1) begin
                    rd_err = 1'b1;
                    if (rnd) rd_ack = 1'($urandom);
                    pend_u = 1'b1; ended = 1'b1;
                end else begin
                    attempts++;
                    if (attempts > RETRY_MAX) begin pend_t = 1'b1; ended = 1'b1; end
                end
            end
            if (got) begin
                hc = 0;
                do begin
                    step(); spur(); set_ctl(0, 1, 1, 0);
                    e_m_data = d;
                    rel = cyc - t0;
                    if (rnd) rdy = (hc >= 20) || ($urandom_range(0, 99) >= 30);
                    else rdy = !(rel >= rlo_s && rel <= rlo_e);
                    m_ready = rdy;
                    hc++;
                end while (!rdy);
                pend_x = 1'b1;
            end
        end
        step(); spur(); set_ctl(0, 0, 1, 1);
        step(); set_ctl(0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1; start = 1'b0; burst_len = 4'd0; rd_ack = 1'b0; rd_err = 1'b0;
        fifo_dout = '0; m_ready = 1'b0;
        set_ctl(0, 0, 0, 0);
        e_underflow = 1'b0; e_timeout = 1'b0; e_m_data = '0; e_xfer = 4'd0;
        pend_x = 1'b0; pend_u = 1'b0; pend_t = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Normal burst of three words.
        fq.delete(); fq.push_back(32'hA); fq.push_back(32'hB); fq.push_back(32'hC);
        run_burst(3, 0, -1, -1, 1'b0);
        chk("norm_rd_n", rd_at.size(), 3);
        chk("norm_rd0", qget(rd_at, 0), 1);
        chk("norm_rd1", qget(rd_at, 1), 4);
        chk("norm_rd2", qget(rd_at, 2), 7);
        chk("norm_mv0", qget(mv_at, 0), 3);
        chk("norm_mv2", qget(mv_at, 2), 9);
        chk("norm_d0", qgetd(mv_d, 0), 32'hA);
        chk("norm_d1", qgetd(mv_d, 1), 32'hB);
        chk("norm_d2", qgetd(mv_d, 2), 32'hC);
        chk("norm_done", done_at, 10);
        chk("norm_xfer", {28'd0, xfer_count}, 3);
        chk("norm_uf", {31'd0, underflow}, 0);
        chk("norm_to", {31'd0, timeout}, 0);

        // Underflow on the third word.
        fq.delete(); fq.push_back(32'h1111); fq.push_back(32'h2222);
        run_burst(4, 0, -1, -1, 1'b0);
        chk("uf_done", done_at, 9);
        chk("uf_xfer", {28'd0, xfer_count}, 2);
        chk("uf_flag", {31'd0, underflow}, 1);
        chk("uf_data", m_data, 32'h2222);

        // Backpressure: m_ready low for cycles 3..7.
        fq.delete(); fq.push_back(32'h55); fq.push_back(32'h66);
        run_burst(2, 0, 3, 7, 1'b0);
        chk("bp_mv_n", mv_at.size(), 7);
        chk("bp_mv8", qget(mv_at, 5), 8);
        chk("bp_d8", qgetd(mv_d, 5), 32'h55);
        chk("bp_rd1", qget(rd_at, 1), 9);
        chk("bp_done", done_at, 12);

        // One lost request, then success.
        fq.delete(); fq.push_back(32'h77);
        run_burst(1, 1, -1, -1, 1'b0);
        chk("col_rd1", qget(rd_at, 1), 3);
        chk("col_mv0", qget(mv_at, 0), 5);
        chk("col_done", done_at, 6);

        // Persistent collision: retries exhausted.
        fq.delete(); fq.push_back(32'h88);
        run_burst(1, 100, -1, -1, 1'b0);
        chk("to_rd_n", rd_at.size(), RETRY_MAX + 1);
        chk("to_flag", {31'd0, timeout}, 1);
        chk("to_done", done_at, 9);

        // Zero length.
        run_burst(0, 0, -1, -1, 1'b0);
        chk("len0_done", done_at, 1);
        chk("len0_rd_n", rd_at.size(), 0);

        // Over-long request clamps to eight words.
        fq.delete();
        for (int i = 0; i < 10; i++) fq.push_back(32'h100 + 32'(i));
        run_burst(12, 0, -1, -1, 1'b0);
        chk("len12_xfer", {28'd0, xfer_count}, 8);
        chk("len12_rd_n", rd_at.size(), 8);
        chk("len12_done", done_at, 25);

        // Reset asserted in HOLD of the second word.
        fq.delete(); fq.push_back(32'hC1); fq.push_back(32'hC2); fq.push_back(32'hC3);
        step(); start = 1'b1; burst_len = 4'd3; t0 = cyc; done_at = -1; set_ctl(0, 0, 0, 0);
        for (int w = 0; w < 2; w++) begin
            step(); spur(); set_ctl(1, 0, 1, 0);
            if (w == 0) begin e_xfer = 4'd0; e_underflow = 1'b0; e_timeout = 1'b0; end
            step(); spur(); set_ctl(0, 0, 1, 0);
            d = fq.pop_front(); rd_ack = 1'b1; fifo_dout = d;
            step(); spur(); set_ctl(0, 1, 1, 0);
            e_m_data = d;
            m_ready = (w == 0);
            if (w == 0) pend_x = 1'b1;
        end
        #2;
        reset = 1'b1;
        set_ctl(0, 0, 0, 0); e_m_data = '0; e_xfer = 4'd0; e_underflow = 1'b0; e_timeout = 1'b0;
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd_en", {31'd0, rd_en}, 0);
        chk("rst_xfer", {28'd0, xfer_count}, 0);
        step(); step();
        reset = 1'b0;
        repeat (3) step();
        chk("rst_no_done", done_at, -1);

        // Randomised bursts.
        for (int b = 0; b < 40; b++) begin
            int n;
            fq.delete();
            n = $urandom_range(0, 9);
            repeat (n) fq.push_back($urandom);
            run_burst($urandom_range(0, 15), 0, -1, -1, 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
